scope_uart_dump: RTL

Sequencer that streams one captured waveform from the sample buffer to the byte-wide UART transmitter as a framed packet. On a start pulse it sends a sync byte, a 16-bit length, the samples read from buffer addresses 0..len, and an 8-bit checksum. It sits between the capture RAM read port and the UART TX byte interface, and is driven by the command/trigger logic.

---
 rtl/scope_uart_dump.sv | 137 +++++++++++++
 1 files changed

// File: rtl/scope_uart_dump.sv
// Streams one captured waveform from the sample buffer to a byte-wide UART
// transmitter as a framed packet: sync byte, 16-bit length, samples 0..len, checksum.
module scope_uart_dump #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] len,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    input  logic [7:0]            mem_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        LEN_HI,
        LEN_LO,
        FETCH,
        LATCH,
        SAMPLE,
        CSUM
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] len_q;
    logic [ADDR_WIDTH-1:0] idx;
    logic [7:0]            csum;
    logic [15:0]           len_ext;
    logic                  xfer;

    assign len_ext = 16'(len_q);
    assign xfer    = tx_valid && tx_ready;

    // The next byte is loaded on the transfer edge so header bytes go out without
    // bubbles; the checksum byte is formed from the running sum plus the last sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            len_q     <= '0;
            idx       <= '0;
            csum      <= '0;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && state != IDLE) begin
                state     <= IDLE;
                tx_valid  <= 1'b0;
                mem_rd_en <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            len_q    <= len;
                            idx      <= '0;
                            csum     <= '0;
                            busy     <= 1'b1;
                            tx_valid <= 1'b1;
                            tx_data  <= SYNC_BYTE;
                            state    <= SYNC;
                        end
                    end
                    SYNC: begin
                        if (xfer) begin
                            tx_data <= len_ext[15:8];
                            state   <= LEN_HI;
                        end
                    end
                    LEN_HI: begin
                        if (xfer) begin
                            csum    <= csum + tx_data;
                            tx_data <= len_ext[7:0];
                            state   <= LEN_LO;
                        end
                    end
                    LEN_LO: begin
                        if (xfer) begin
                            csum      <= csum + tx_data;
                            tx_valid  <= 1'b0;
                            mem_addr  <= idx;
                            mem_rd_en <= 1'b1;
                            state     <= FETCH;
                        end
                    end
                    FETCH: begin
                        mem_rd_en <= 1'b0;
                        state     <= LATCH;
                    end
                    LATCH: begin
                        tx_data  <= mem_data;
                        tx_valid <= 1'b1;
                        state    <= SAMPLE;
                    end
                    SAMPLE: begin
                        if (xfer) begin
                            csum <= csum + tx_data;
                            if (idx == len_q) begin
                                tx_data <= csum + tx_data;
                                state   <= CSUM;
                            end else begin
                                idx       <= idx + 1'b1;
                                mem_addr  <= idx + 1'b1;
                                mem_rd_en <= 1'b1;
                                tx_valid  <= 1'b0;
                                state     <= FETCH;
                            end
                        end
                    end
                    CSUM: begin
                        if (xfer) begin
                            tx_valid <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
